cd_upload_writer: RTL and testbench
===================================

// Module: cd_upload_writer
// PURPOSE
//  Memory-side consumer of the CD upload write strobes (CD_TR_WR_SPR/PCM/Z80/FIX).
//  Captures each upload write, maps it to a byte address in the shared external
//  memory for its area and bank, buffers it in a small FIFO and issues it as a
//  req/ack memory write.
//  Sits between the CD system register block and the memory arbiter.
// PARAMETERS
//  DEPTH     4            FIFO entries, power of 2, >=2
//  Z80_BASE  25'h0000000  byte base of Z80 RAM image (64KB)
//  FIX_BASE  25'h0020000  byte base of FIX RAM image (128KB)
//  PCM_BASE  25'h0100000  byte base of PCM RAM image (1MB, 2 banks)
//  SPR_BASE  25'h0400000  byte base of SPR RAM image (4MB, 4 banks)
// PORTS
//  CLK_68KCLK     in   1   clock; all state on rising edge
//  nRESET         in   1   async active-low reset
//  CD_TR_WR_SPR   in   1   sprite upload write strobe
//  CD_TR_WR_PCM   in   1   PCM upload write strobe
//  CD_TR_WR_Z80   in   1   Z80 upload write strobe
//  CD_TR_WR_FIX   in   1   fix upload write strobe
//  CD_TR_WR_ADDR  in   19  68K word address [19:1] in upload window
//  CD_TR_WR_DATA  in   16  68K write data
//  CD_BANK_SPR    in   2   sprite bank
//  CD_BANK_PCM    in   1   PCM bank
//  MEM_REQ        out  1   write request, level, held until ack
//  MEM_ACK        in   1   1-cycle ack from arbiter
//  MEM_ADDR       out  25  byte address
//  MEM_DATA       out  16  write data, [15:8] = even byte
//  MEM_BE         out  2   byte enables, [1] = even byte, [0] = odd byte
//  FIFO_FULL      out  1   FIFO holds DEPTH entries
//  BUSY           out  1   FIFO non-empty or MEM_REQ high
//  OVERFLOW       out  1   sticky: a write was dropped
//  CLR_OVERFLOW   in   1   clears OVERFLOW
// BEHAVIOUR
//  Reset: MEM_REQ=0, MEM_ADDR=0, MEM_DATA=0, MEM_BE=0, FIFO_FULL=0, BUSY=0,
//   OVERFLOW=0. FIFO pointers and count are 0; FSM is IDLE.
//  Reset asserted mid-transaction: FIFO is flushed and MEM_REQ drops immediately.
//   Any MEM_ACK arriving afterwards is ignored.
//  Strobe capture:
//   - Rising-edge detect per strobe (high now, low on previous edge). A strobe
//     held high enqueues only once.
//   - Same-edge rises: priority SPR>PCM>Z80>FIX. Only the winner enqueues; the
//     others are dropped and OVERFLOW is set.
//  Address mapping (computed at capture, banks sampled on the same edge):
//   - SPR: addr = SPR_BASE + {BANK_SPR, ADDR[19:1], 1'b0}; data = DATA; BE = 11
//   - PCM: a = PCM_BASE + {BANK_PCM, ADDR[19:1]}
//   - Z80: a = Z80_BASE + ADDR[16:1]
//   - FIX: a = FIX_BASE + ADDR[17:1]
//   - PCM/Z80/FIX are byte writes of DATA[7:0]: MEM_DATA = {D[7:0], D[7:0]},
//     BE = a[0] ? 01 : 10.
//   - Additions wrap modulo 2^25.
//  FIFO:
//   - An entry is {addr 25, data 16, be 2}.
//   - Enqueue when full: the write is dropped and OVERFLOW is set.
//   - Same-edge enqueue and pop: count is unchanged, so an enqueue is accepted
//     even when full.
//   - CLR_OVERFLOW has lower priority than a same-edge set; OVERFLOW stays 1.
//  FSM:
//   - IDLE: if FIFO non-empty, load head into MEM_ADDR/DATA/BE, set MEM_REQ=1,
//     go to ISSUE.
//   - ISSUE: outputs stay stable. On MEM_ACK=1: pop, MEM_REQ=0, go to IDLE.
//   - MEM_REQ is low for at least one cycle between transactions.
//   - MEM_ACK in IDLE is ignored.
//  Latency: strobe edge at edge N (empty FIFO, IDLE) -> MEM_REQ=1 after edge N+1.
//   Ack sampled at edge M -> MEM_REQ=0 after edge M; next REQ after edge M+1.
//  FIFO_FULL and BUSY are registered, derived from post-edge state.
// TESTING
//  1. SPR: BANK_SPR=2, ADDR=19'h00010, DATA=16'hA55A, one strobe ->
//     MEM_ADDR=25'h0600020, MEM_DATA=16'hA55A, MEM_BE=11, one REQ.
//     Ack after 3 cycles -> REQ drops; BUSY=0 next cycle.
//  2. FIX: ADDR=19'h00003, DATA=16'h12C4 -> MEM_ADDR=25'h0020003,
//     MEM_DATA=16'hC4C4, MEM_BE=01.
//     Z80: ADDR=19'h10000 -> MEM_ADDR=25'h0000000 (bits above 16 ignored).
//  3. MEM_ACK tied low, 5 PCM strobes with DEPTH=4 -> FIFO_FULL=1 after the 4th,
//     5th dropped, OVERFLOW=1. Release ack -> exactly 4 writes in order.
//     CLR_OVERFLOW -> OVERFLOW=0.
//  4. SPR and FIX strobes rise on the same edge -> only the SPR write is issued;
//     OVERFLOW=1. A strobe held 3 cycles -> exactly one write.
//  5. nRESET pulsed low while MEM_REQ=1 with 2 entries queued -> MEM_REQ=0 at
//     once, BUSY=0. A late MEM_ACK after release -> no writes issued.
//  6. Back-to-back: strobes every 2 cycles, ack 1 cycle after each REQ ->
//     no drops, REQ low for 1 cycle between writes, addresses in strobe order.

Source files
------------

// File: rtl/cd_upload_writer_if.sv
// Memory write bus between the CD upload writer and the memory arbiter.
// The writer holds a level request until the arbiter returns a one-cycle ack.
interface cd_upload_writer_if;
  logic        MEM_REQ;
  logic        MEM_ACK;
  logic [24:0] MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic [1:0]  MEM_BE;

  modport master (output MEM_REQ, MEM_ADDR, MEM_DATA, MEM_BE, input MEM_ACK);
  modport slave  (input MEM_REQ, MEM_ADDR, MEM_DATA, MEM_BE, output MEM_ACK);
endinterface

// File: rtl/cd_upload_writer.sv
// Captures CD upload write strobes, maps each one to an external-memory byte
// address, buffers the writes in a small FIFO and issues them over a req/ack bus.
module cd_upload_writer #(
  parameter int          DEPTH    = 4,
  parameter logic [24:0] Z80_BASE = 25'h0000000,
  parameter logic [24:0] FIX_BASE = 25'h0020000,
  parameter logic [24:0] PCM_BASE = 25'h0100000,
  parameter logic [24:0] SPR_BASE = 25'h0400000
) (
  input  logic               CLK_68KCLK,
  input  logic               nRESET,
  input  logic               CD_TR_WR_SPR,
  input  logic               CD_TR_WR_PCM,
  input  logic               CD_TR_WR_Z80,
  input  logic               CD_TR_WR_FIX,
  input  logic [18:0]        CD_TR_WR_ADDR,
  input  logic [15:0]        CD_TR_WR_DATA,
  input  logic [1:0]         CD_BANK_SPR,
  input  logic               CD_BANK_PCM,
  cd_upload_writer_if.master mem,
  output logic               FIFO_FULL,
  output logic               BUSY,
  output logic               OVERFLOW,
  input  logic               CLR_OVERFLOW
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state, state_next;
  logic [3:0]    strobe, strobe_q, rise;
  logic          any_rise, multi_rise, push, pop, load, ovf_set;
  logic [24:0]   cap_addr;
  logic [15:0]   cap_data;
  logic [1:0]    cap_be;
  logic [42:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;

  // Bit order doubles as the arbitration priority: SPR > PCM > Z80 > FIX.
  assign strobe     = {CD_TR_WR_SPR, CD_TR_WR_PCM, CD_TR_WR_Z80, CD_TR_WR_FIX};
  assign rise       = strobe & ~strobe_q;
  assign any_rise   = |rise;
  assign multi_rise = (rise & (rise - 4'd1)) != 4'd0;

  always_comb begin
    cap_addr = '0;
    cap_data = {CD_TR_WR_DATA[7:0], CD_TR_WR_DATA[7:0]};
    if (rise[3]) begin
      cap_addr = SPR_BASE + {3'b000, CD_BANK_SPR, CD_TR_WR_ADDR, 1'b0};
      cap_data = CD_TR_WR_DATA;
    end else if (rise[2]) begin
      cap_addr = PCM_BASE + {5'b00000, CD_BANK_PCM, CD_TR_WR_ADDR};
    end else if (rise[1]) begin
      cap_addr = Z80_BASE + {9'b0, CD_TR_WR_ADDR[15:0]};
    end else begin
      cap_addr = FIX_BASE + {8'b0, CD_TR_WR_ADDR[16:0]};
    end
    cap_be = rise[3] ? 2'b11 : (cap_addr[0] ? 2'b01 : 2'b10);
  end

  // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
  assign pop     = (state == ISSUE) && mem.MEM_ACK;
  assign push    = any_rise && ((count != (AW+1)'(DEPTH)) || pop);
  assign ovf_set = multi_rise || (any_rise && !push);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (!push && pop)
      count_next = count - (AW+1)'(1);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem.MEM_ACK)
          state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (push)
      fifo_mem[wr_ptr] <= {cap_addr, cap_data, cap_be};
  end

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state        <= IDLE;
      strobe_q     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      mem.MEM_REQ  <= 1'b0;
      mem.MEM_ADDR <= '0;
      mem.MEM_DATA <= '0;
      mem.MEM_BE   <= '0;
      FIFO_FULL    <= 1'b0;
      BUSY         <= 1'b0;
      OVERFLOW     <= 1'b0;
    end else begin
      state    <= state_next;
      strobe_q <= strobe;
      count    <= count_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      mem.MEM_REQ <= (state_next == ISSUE);
      if (load)
        {mem.MEM_ADDR, mem.MEM_DATA, mem.MEM_BE} <= fifo_mem[rd_ptr];
      FIFO_FULL <= (count_next == (AW+1)'(DEPTH));
      BUSY      <= (count_next != '0) || (state_next == ISSUE);
      // A same-edge drop wins over the clear request.
      if (ovf_set)
        OVERFLOW <= 1'b1;
      else if (CLR_OVERFLOW)
        OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cd_upload_writer.sv
// Randomized and directed bench for cd_upload_writer: a queue-based reference
// model predicts every memory write and status flag; a monitor checks issued writes.
module tb_cd_upload_writer;
  localparam int          DEPTH    = 4;
  localparam logic [24:0] Z80_BASE = 25'h0000000;
  localparam logic [24:0] FIX_BASE = 25'h0020000;
  localparam logic [24:0] PCM_BASE = 25'h0100000;
  localparam logic [24:0] SPR_BASE = 25'h0400000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spr = 1'b0, pcm = 1'b0, z80 = 1'b0, fix = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  bank_spr = '0;
  logic        bank_pcm = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        fifo_full, busy, overflow;

  cd_upload_writer_if bus();

  cd_upload_writer #(.DEPTH(DEPTH)) dut (
    .CLK_68KCLK   (clk),
    .nRESET       (rst_n),
    .CD_TR_WR_SPR (spr),
    .CD_TR_WR_PCM (pcm),
    .CD_TR_WR_Z80 (z80),
    .CD_TR_WR_FIX (fix),
    .CD_TR_WR_ADDR(wr_addr),
    .CD_TR_WR_DATA(wr_data),
    .CD_BANK_SPR  (bank_spr),
    .CD_BANK_PCM  (bank_pcm),
    .mem          (bus),
    .FIFO_FULL    (fifo_full),
    .BUSY         (busy),
    .OVERFLOW     (overflow),
    .CLR_OVERFLOW (clr_ovf)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [42:0] exp_q[$];
  int          model_count = 0;
  logic        model_req = 1'b0;
  logic        model_ovf = 1'b0;
  logic [3:0]  prev_stb = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Address map written as plain byte arithmetic; the 25-bit slice is the wrap.
  function automatic logic [42:0] expected_entry(input logic [3:0] win, input logic [18:0] a,
                                                 input logic [15:0] d, input logic [1:0] bs,
                                                 input logic bp);
    int unsigned byte_addr;
    logic [24:0] ad;
    logic [15:0] dd;
    logic [1:0]  be;
    if (win[3])      byte_addr = 32'(SPR_BASE) + 32'(bs) * 32'h100000 + 32'(a) * 2;
    else if (win[2]) byte_addr = 32'(PCM_BASE) + 32'(bp) * 32'h80000 + 32'(a);
    else if (win[1]) byte_addr = 32'(Z80_BASE) + (32'(a) % 32'h10000);
    else             byte_addr = 32'(FIX_BASE) + (32'(a) % 32'h20000);
    ad = byte_addr[24:0];
    dd = win[3] ? d : {d[7:0], d[7:0]};
    be = win[3] ? 2'b11 : (ad[0] ? 2'b01 : 2'b10);
    return {ad, dd, be};
  endfunction

  task automatic check_output();
    check("req",  64'(bus.MEM_REQ), 64'(model_req));
    check("full", 64'(fifo_full),   64'(model_count == DEPTH));
    check("busy", 64'(busy),        64'(model_count != 0));
    check("ovf",  64'(overflow),    64'(model_ovf));
  endtask

  // ack_mode: 0 = no ack, 1 = ack while a request is pending, 2 = ack forced high.
  task automatic apply_stimulus(input logic [3:0] stb, input logic [18:0] a, input logic [15:0] d,
                                input logic [1:0] bs, input logic bp, input logic clr,
                                input int ack_mode);
    logic       ack, pop, set;
    logic [3:0] rise, win;
    {spr, pcm, z80, fix} = stb;
    wr_addr  = a;
    wr_data  = d;
    bank_spr = bs;
    bank_pcm = bp;
    clr_ovf  = clr;
    ack = (ack_mode == 2) || (ack_mode == 1 && model_req);
    bus.MEM_ACK = ack;
    @(posedge clk);
    rise = stb & ~prev_stb;
    prev_stb = stb;
    pop = ack && model_req;
    if (model_req && pop) model_req = 1'b0;
    else if (!model_req && model_count > 0) model_req = 1'b1;
    set = 1'b0;
    if (rise != 4'd0) begin
      win = rise[3] ? 4'b1000 : rise[2] ? 4'b0100 : rise[1] ? 4'b0010 : 4'b0001;
      if ($countones(rise) > 1) set = 1'b1;
      if (model_count < DEPTH || pop) begin
        exp_q.push_back(expected_entry(win, a, d, bs, bp));
        model_count++;
      end else begin
        set = 1'b1;
      end
    end
    if (pop) model_count--;
    if (set) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    @(negedge clk);
    check_output();
  endtask

  task automatic idle(input int n, input int ack_mode);
    for (int i = 0; i < n; i++) apply_stimulus(4'd0, '0, '0, '0, 1'b0, 1'b0, ack_mode);
  endtask

  task automatic pulse(input logic [3:0] stb, input logic [18:0] a, input logic [15:0] d,
                       input logic [1:0] bs, input logic bp, input int ack_mode);
    apply_stimulus(stb, a, d, bs, bp, 1'b0, ack_mode);
    apply_stimulus(4'd0, a, d, bs, bp, 1'b0, ack_mode);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (model_count > 0 || model_req); i++) idle(1, 1);
    idle(2, 0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares each newly issued write with the scoreboard head and
  // checks that the bus stays stable while the request is held.
  logic        req_seen = 1'b0;
  logic [42:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_seen = 1'b0;
    end else if (bus.MEM_REQ && !req_seen) begin
      req_seen = 1'b1;
      held = {bus.MEM_ADDR, bus.MEM_DATA, bus.MEM_BE};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL write: unexpected write %h with empty scoreboard at %0t", held, $time);
      end else begin
        check("write", 64'(held), 64'(exp_q.pop_front()));
      end
    end else if (bus.MEM_REQ) begin
      check("stable", 64'({bus.MEM_ADDR, bus.MEM_DATA, bus.MEM_BE}), 64'(held));
    end else begin
      req_seen = 1'b0;
    end
  end

  initial begin
    bus.MEM_ACK = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",  64'(bus.MEM_REQ), 64'd0);
    check("rst_bus",  64'({bus.MEM_ADDR, bus.MEM_DATA, bus.MEM_BE}), 64'd0);
    check("rst_flag", 64'({fifo_full, busy, overflow}), 64'd0);
    rst_n = 1'b1;
    idle(2, 0);

    $display("[TB] sprite write with delayed ack");
    pulse(4'b1000, 19'h00010, 16'hA55A, 2'd2, 1'b0, 0);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);

    $display("[TB] fix and z80 byte writes");
    pulse(4'b0001, 19'h00003, 16'h12C4, 2'd0, 1'b0, 1);
    drain();
    pulse(4'b0010, 19'h10000, 16'h00FF, 2'd0, 1'b0, 1);
    drain();

    $display("[TB] fifo overflow with ack held low");
    for (int i = 0; i < 5; i++) pulse(4'b0100, 19'(i * 3 + 1), 16'(16'h1100 + i), 2'd0, 1'(i), 0);
    drain();
    apply_stimulus(4'd0, '0, '0, '0, 1'b0, 1'b1, 0);

    $display("[TB] simultaneous strobes and held strobe");
    pulse(4'b1001, 19'h00044, 16'hBEEF, 2'd1, 1'b0, 0);
    drain();
    apply_stimulus(4'd0, '0, '0, '0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0010, 19'h00123, 16'h0077, 2'd0, 1'b0, 1'b0, 1);
    idle(1, 1);
    drain();

    $display("[TB] reset during a transaction");
    pulse(4'b0100, 19'h00020, 16'h0033, 2'd0, 1'b1, 0);
    pulse(4'b0100, 19'h00021, 16'h0044, 2'd0, 1'b1, 0);
    idle(1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req",  64'(bus.MEM_REQ), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    model_count = 0;
    model_req = 1'b0;
    model_ovf = 1'b0;
    prev_stb = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 2);
    idle(4, 0);

    $display("[TB] back-to-back strobes");
    for (int i = 0; i < 8; i++) pulse((i % 2 == 0) ? 4'b0100 : 4'b0010, 19'(i * 5), 16'(i * 17), 2'd0, 1'b0, 1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [3:0] stb;
      stb = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
      apply_stimulus(stb, 19'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                     $urandom_range(0, 15) == 0, int'($urandom_range(0, 1)));
    end
    apply_stimulus(4'd0, '0, '0, '0, 1'b0, 1'b0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
